// File: rtl/radio_slot_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// radio_slot_pkg - state encoding and shared constants for the slot sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package radio_slot_pkg;

    localparam int unsigned CNT_W          = 12;
    localparam int unsigned RX_WDOG_US_DEF = 3125;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_TX        = 3'd2,
        ST_RX_LISTEN = 3'd3,
        ST_RX_ACTIVE = 3'd4
    } state_t;

    // A zero-length load would never expire, so it is treated as one microsecond.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/radio_slot_seq_us_down_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// us_down_counter - microsecond down-counter with an expiry strobe
// Rev 1.0
// ----------------------------------------------------------------------------
module us_down_counter
    import radio_slot_pkg::*;
(
    input  logic             clk_6M,
    input  logic             rstz,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expire_p_o
);

    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A load takes precedence over a coincident strobe; the count parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - C_ONE;
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_p_o = dec_i && (cnt_q == C_ONE);

endmodule
`default_nettype wire

// File: rtl/radio_slot_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// radio_slot_seq - per-slot PLL / TX / RX-window sequencer for the RF front end
// Rev 1.0
// ----------------------------------------------------------------------------
module radio_slot_seq
    import radio_slot_pkg::*;
#(
    parameter int unsigned RX_WDOG_US = RX_WDOG_US_DEF
) (
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        p_1us,
    input  logic        slot_p,
    input  logic        half_slot_p,
    input  logic        clk_bit1,
    input  logic        fkset_p,
    input  logic        is_master,
    input  logic        tx_req,
    input  logic [11:0] tx_len_us,
    input  logic        rx_enable,
    input  logic [9:0]  rx_win_us,
    input  logic        sync_found_p,
    input  logic        rx_done_p,
    input  logic        abort_p,
    output logic        pll_en,
    output logic        pll_load_p,
    output logic        tx_en,
    output logic        tx_start_p,
    output logic        tx_done_p,
    output logic        rx_en,
    output logic        rx_timeout_p,
    output logic        rx_abort_p,
    output logic [2:0]  state
);

    localparam logic [CNT_W-1:0] C_WDOG = at_least_one(CNT_W'(RX_WDOG_US));

    state_t state_q;
    logic   half_flag_q;
    logic   next_tx_q;
    logic   pll_en_q;
    logic   pll_load_q;
    logic   tx_en_q;
    logic   tx_start_q;
    logic   tx_done_q;
    logic   rx_en_q;
    logic   rx_timeout_q;
    logic   rx_abort_q;

    logic             go_tx;
    logic             go_rx;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_expire_p;

    // Counter loads happen in the same cycle as the FSM decision that needs them.
    always_comb begin
        go_tx        = next_tx_q && tx_req;
        go_rx        = !next_tx_q && rx_enable;
        cnt_load     = 1'b0;
        cnt_load_val = at_least_one(tx_len_us);
        if (!abort_p) begin
            case (state_q)
                ST_SETTLE: begin
                    if (slot_p && (go_tx || go_rx)) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = go_tx ? at_least_one(tx_len_us)
                                             : at_least_one({{(CNT_W-10){1'b0}}, rx_win_us});
                    end
                end
                ST_RX_LISTEN: begin
                    if (sync_found_p) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = C_WDOG;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    us_down_counter u_us_cnt (
        .clk_6M     (clk_6M),
        .rstz       (rstz),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (p_1us),
        .expire_p_o (cnt_expire_p)
    );

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q      <= ST_IDLE;
            half_flag_q  <= 1'b0;
            next_tx_q    <= 1'b0;
            pll_en_q     <= 1'b0;
            pll_load_q   <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_done_q    <= 1'b0;
            rx_en_q      <= 1'b0;
            rx_timeout_q <= 1'b0;
            rx_abort_q   <= 1'b0;
        end else begin
            pll_load_q   <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_done_q    <= 1'b0;
            rx_timeout_q <= 1'b0;
            rx_abort_q   <= 1'b0;

            if (slot_p) begin
                half_flag_q <= 1'b0;
            end else if (half_slot_p) begin
                half_flag_q <= 1'b1;
            end

            if (abort_p) begin
                state_q  <= ST_IDLE;
                pll_en_q <= 1'b0;
                tx_en_q  <= 1'b0;
                rx_en_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // Only a retune point in the second half of a slot arms the next slot.
                        if (fkset_p && half_flag_q) begin
                            next_tx_q  <= is_master ? clk_bit1 : !clk_bit1;
                            pll_load_q <= 1'b1;
                            pll_en_q   <= 1'b1;
                            state_q    <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (slot_p) begin
                            if (go_tx) begin
                                tx_en_q    <= 1'b1;
                                tx_start_q <= 1'b1;
                                state_q    <= ST_TX;
                            end else if (go_rx) begin
                                rx_en_q <= 1'b1;
                                state_q <= ST_RX_LISTEN;
                            end else begin
                                pll_en_q <= 1'b0;
                                state_q  <= ST_IDLE;
                            end
                        end
                    end
                    ST_TX: begin
                        if (cnt_expire_p) begin
                            tx_en_q   <= 1'b0;
                            pll_en_q  <= 1'b0;
                            tx_done_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end
                    ST_RX_LISTEN: begin
                        if (sync_found_p) begin
                            state_q <= ST_RX_ACTIVE;
                        end else if (cnt_expire_p) begin
                            rx_en_q      <= 1'b0;
                            pll_en_q     <= 1'b0;
                            rx_timeout_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end
                    end
                    ST_RX_ACTIVE: begin
                        // A clean end of packet masks a watchdog expiry in the same cycle.
                        if (rx_done_p || cnt_expire_p) begin
                            rx_en_q    <= 1'b0;
                            pll_en_q   <= 1'b0;
                            rx_abort_q <= !rx_done_p;
                            state_q    <= ST_IDLE;
                        end
                    end
                    default: begin
                        pll_en_q <= 1'b0;
                        tx_en_q  <= 1'b0;
                        rx_en_q  <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign pll_en       = pll_en_q;
    assign pll_load_p   = pll_load_q;
    assign tx_en        = tx_en_q;
    assign tx_start_p   = tx_start_q;
    assign tx_done_p    = tx_done_q;
    assign rx_en        = rx_en_q;
    assign rx_timeout_p = rx_timeout_q;
    assign rx_abort_p   = rx_abort_q;
    assign state        = state_q;

endmodule
`default_nettype wire

// File: doc/radio_slot_seq.md
# radio_slot_seq

Per-slot radio sequencer sitting directly downstream of the Bluetooth clock/timeslot generator. It consumes that block's slot pulses, half-slot pulses, `CLK[1]` and `fkset_p` (PLL retune point) and turns them into PLL enable/load, TX enable and RX-window enable for the RF front end. It decides the direction of each upcoming slot from role and clock phase, and times TX bursts and RX listen windows in 1 µs units.

## Interface
Parameters:
- `RX_WDOG_US`, default 3125. Maximum RX_ACTIVE duration in µs (5 slots).

Ports (name, direction, width, meaning):
- `clk_6M`, in, 1. 6 MHz clock.
- `rstz`, in, 1. Reset, asynchronous, active-low.
- `p_1us`, in, 1. 1 µs strobe.
- `slot_p`, in, 1. Slot boundary pulse (`tslot_p` of the active role).
- `half_slot_p`, in, 1. Half-slot pulse of the active role.
- `clk_bit1`, in, 1. `CLK[1]` of the active role.
- `fkset_p`, in, 1. PLL retune point.
- `is_master`, in, 1. Role select.
- `tx_req`, in, 1. A packet is queued for the next TX slot.
- `tx_len_us`, in, 12. TX burst length in µs, sampled at TX start.
- `rx_enable`, in, 1. Listen in RX slots.
- `rx_win_us`, in, 10. RX sync-search window in µs.
- `sync_found_p`, in, 1. Access-code correlator hit.
- `rx_done_p`, in, 1. Packet reception finished.
- `abort_p`, in, 1. Immediate stop.
- `pll_en`, out, 1. PLL enable.
- `pll_load_p`, out, 1. Frequency load strobe.
- `tx_en`, out, 1. TX enable.
- `tx_start_p`, out, 1. TX start pulse.
- `tx_done_p`, out, 1. TX done pulse.
- `rx_en`, out, 1. RX enable.
- `rx_timeout_p`, out, 1. Window expired without a sync hit.
- `rx_abort_p`, out, 1. RX watchdog fired.
- `state`, out, 3. Current state, for debug.

## Operation
- `half_flag` register: set on `half_slot_p`, cleared on `slot_p`. When both pulse in the same cycle, `slot_p` wins.
- States: IDLE=0, SETTLE=1, TX=2, RX_LISTEN=3, RX_ACTIVE=4.
- IDLE:
  - `fkset_p` with `half_flag`=1: latch `next_tx` = `is_master ? clk_bit1 : !clk_bit1`, pulse `pll_load_p`, set `pll_en`, go to SETTLE.
  - `fkset_p` with `half_flag`=0: ignored.
- SETTLE, on `slot_p`:
  - `next_tx` & `tx_req`: go to TX. Set `tx_en`, pulse `tx_start_p`, load counter with `max(tx_len_us,1)`.
  - `!next_tx` & `rx_enable`: go to RX_LISTEN. Set `rx_en`, load counter with `max(rx_win_us,1)`.
  - Otherwise: go to IDLE and clear `pll_en`.
- TX: counter decrements on `p_1us`. On the `p_1us` where it reads 1: clear `tx_en`, clear `pll_en`, pulse `tx_done_p`, go to IDLE.
- RX_LISTEN: counter decrements on `p_1us`.
  - `sync_found_p`: go to RX_ACTIVE, load counter with `RX_WDOG_US`.
  - Counter expiry (reads 1 on `p_1us`): clear `rx_en`, clear `pll_en`, pulse `rx_timeout_p`, go to IDLE.
  - `sync_found_p` in the same cycle as expiry: sync wins.
- RX_ACTIVE:
  - `rx_done_p`: go to IDLE, clear `rx_en` and `pll_en`.
  - Watchdog expiry: same exit plus pulse `rx_abort_p`.
  - `rx_done_p` and watchdog expiry in the same cycle: `rx_done_p` wins, no `rx_abort_p`.
- `fkset_p` outside IDLE: ignored (multi-slot packet in progress).
- `abort_p` in any state: next cycle is IDLE with all enables 0 and no done/timeout pulse. It has priority over every other event.
- `sync_found_p` and `rx_done_p` outside their states: ignored.
- Counter width is 12 bits. `rx_win_us` is zero-extended. Loads of 0 are forced to 1.

## Timing
- All outputs are registered. Reset values: every output 0, `state`=IDLE, `half_flag`=0, counter=0.
- `pll_load_p`, `pll_en`: assert one cycle after the `fkset_p` cycle.
- `tx_en`, `tx_start_p`, `rx_en`: assert one cycle after the `slot_p` cycle.
- `tx_en` stays high for exactly N `p_1us` strobes (N=`max(tx_len_us,1)`). It falls, and `tx_done_p` pulses, on the cycle after the Nth strobe.
- Pulse outputs are exactly one `clk_6M` cycle wide.
- An `rstz` assertion mid-operation clears everything asynchronously. After release the block waits for a fresh `fkset_p`.

## Structure
- Shared package `radio_slot_pkg`: state encoding, the `RX_WDOG_US` default, and the 12-bit counter width constant.
- One sub-module, `us_down_counter`: load value, load strobe, `p_1us` decrement, and an `expire_p` output when decrementing from 1.

## Test plan
- Master, `clk_bit1`=1, `tx_req`=1, `tx_len_us`=366, `half_flag` set, `fkset_p` -> `pll_en` next cycle. On `slot_p`, `tx_en` is high for 366 `p_1us` strobes, then `tx_done_p` and IDLE.
- Slave, `clk_bit1`=1, `rx_enable`=1, `rx_win_us`=20, no sync -> `rx_en` for 20 µs, then `rx_timeout_p`, `pll_en`=0.
- RX with `sync_found_p` at µs 10, then `rx_done_p` at µs 400 -> `state` goes 3→4→0, no `rx_timeout_p`.
- RX_ACTIVE with no `rx_done_p` -> `rx_abort_p` after 3125 µs. Also `rx_done_p` coincident with expiry -> no `rx_abort_p`.
- `fkset_p` with `half_flag`=0 -> no response. `fkset_p` during TX -> ignored. `abort_p` mid-TX -> all enables 0 next cycle, no `tx_done_p`.
- `rstz` pulsed mid-RX -> all outputs 0 immediately. `tx_len_us`=0 -> `tx_en` for exactly 1 µs.
